// File: rtl/rx_frame_assembler.sv
// Command-frame assembler: collects operand1, operand2 and opcode bytes from the
// UART receiver and holds the finished command on a valid/ready handshake.
module rx_frame_assembler #(
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned OPERAND_BYTES  = 2,
    parameter int unsigned OPCODE_BITS    = 6,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_data_ready,
    input  logic [DATA_BITS-1:0]               i_data,
    input  logic                               i_ready,
    output logic [DATA_BITS*OPERAND_BYTES-1:0] o_operand1,
    output logic [DATA_BITS*OPERAND_BYTES-1:0] o_operand2,
    output logic [OPCODE_BITS-1:0]             o_opcode,
    output logic                               o_valid,
    output logic                               o_busy,
    output logic                               o_overrun,
    output logic                               o_timeout
);

    localparam int unsigned W  = DATA_BITS * OPERAND_BYTES;
    localparam int unsigned IW = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(OPERAND_BYTES - 1);
    localparam logic [CW-1:0] IDLE_MAX = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {S_OP1, S_OP2, S_OPC, S_HOLD} state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [CW-1:0]          idle_q;
    logic                   prev_q;
    logic [W-1:0]           op1_sh_q, op2_sh_q;
    logic [W-1:0]           op1_q, op2_q;
    logic [OPCODE_BITS-1:0] opc_q;
    logic                   valid_q, overrun_q, timeout_q;

    logic byte_ev, busy, accept, timeout_hit;

    assign byte_ev     = i_data_ready & ~prev_q;
    assign busy        = ((state_q == S_OP1) && (idx_q != '0)) ||
                         (state_q == S_OP2) || (state_q == S_OPC);
    assign accept      = valid_q & i_ready;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && busy && (idle_q == IDLE_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_OP1;
            idx_q     <= '0;
            idle_q    <= '0;
            prev_q    <= 1'b1;
            op1_sh_q  <= '0;
            op2_sh_q  <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            opc_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            prev_q    <= i_data_ready;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            // Counter wrap past IDLE_MAX is harmless: the abort leaves busy low next cycle.
            if (byte_ev || !busy)
                idle_q <= '0;
            else
                idle_q <= idle_q + 1'b1;

            case (state_q)
                S_OP1: begin
                    if (byte_ev) begin
                        for (int unsigned b = 0; b < OPERAND_BYTES; b++)
                            if (idx_q == IW'(b))
                                op1_sh_q[b*DATA_BITS +: DATA_BITS] <= i_data;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_OP2;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        idx_q     <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                S_OP2: begin
                    if (byte_ev) begin
                        for (int unsigned b = 0; b < OPERAND_BYTES; b++)
                            if (idx_q == IW'(b))
                                op2_sh_q[b*DATA_BITS +: DATA_BITS] <= i_data;
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_OPC;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state_q   <= S_OP1;
                        idx_q     <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                S_OPC: begin
                    if (byte_ev) begin
                        op1_q   <= op1_sh_q;
                        op2_q   <= op2_sh_q;
                        opc_q   <= i_data[OPCODE_BITS-1:0];
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else if (timeout_hit) begin
                        state_q   <= S_OP1;
                        idx_q     <= '0;
                        timeout_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        valid_q <= 1'b0;
                        if (byte_ev) begin
                            // A byte coinciding with acceptance starts the next frame.
                            op1_sh_q[DATA_BITS-1:0] <= i_data;
                            if (OPERAND_BYTES == 1) begin
                                state_q <= S_OP2;
                                idx_q   <= '0;
                            end else begin
                                state_q <= S_OP1;
                                idx_q   <= IW'(1);
                            end
                        end else begin
                            state_q <= S_OP1;
                            idx_q   <= '0;
                        end
                    end else if (byte_ev) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_OP1;
                    idx_q   <= '0;
                end
            endcase
        end
    end

    assign o_operand1 = op1_q;
    assign o_operand2 = op2_q;
    assign o_opcode   = opc_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy;
    assign o_overrun  = overrun_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_rx_frame_assembler.sv
// Directed bench for rx_frame_assembler: default build plus 1-byte and 4-byte operand builds
// sharing the same input stimulus.
module tb_rx_frame_assembler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       strb = 1'b0;
    logic [7:0] data = '0;
    logic       rdy = 1'b0;

    logic [15:0] a_op1, a_op2;
    logic [5:0]  a_opc;
    logic        a_valid, a_busy, a_ovr, a_to;
    logic [7:0]  b_op1, b_op2;
    logic [5:0]  b_opc;
    logic        b_valid, b_busy, b_ovr, b_to;
    logic [31:0] c_op1, c_op2;
    logic [5:0]  c_opc;
    logic        c_valid, c_busy, c_ovr, c_to;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rx_frame_assembler u0 (
        .i_clk(clk), .i_rst(rst), .i_data_ready(strb), .i_data(data), .i_ready(rdy),
        .o_operand1(a_op1), .o_operand2(a_op2), .o_opcode(a_opc), .o_valid(a_valid),
        .o_busy(a_busy), .o_overrun(a_ovr), .o_timeout(a_to)
    );

    rx_frame_assembler #(.OPERAND_BYTES(1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_data_ready(strb), .i_data(data), .i_ready(rdy),
        .o_operand1(b_op1), .o_operand2(b_op2), .o_opcode(b_opc), .o_valid(b_valid),
        .o_busy(b_busy), .o_overrun(b_ovr), .o_timeout(b_to)
    );

    rx_frame_assembler #(.OPERAND_BYTES(4)) u4 (
        .i_clk(clk), .i_rst(rst), .i_data_ready(strb), .i_data(data), .i_ready(rdy),
        .o_operand1(c_op1), .o_operand2(c_op2), .o_opcode(c_opc), .o_valid(c_valid),
        .o_busy(c_busy), .o_overrun(c_ovr), .o_timeout(c_to)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise the strobe for one cycle; returns in the cycle after the byte event.
    task automatic strobe(input logic [7:0] b);
        data = b;
        strb = 1'b1;
        tick();
        strb = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        strobe(b);
        tick();
    endtask

    task automatic send_long(input logic [7:0] b);
        data = b;
        strb = 1'b1;
        repeat (10) tick();
        strb = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with strobe held high through release
        strb = 1'b1;
        rdy  = 1'b1;
        tick();
        tick();
        chk("rst_op1", a_op1, 64'h0);
        chk("rst_op2", a_op2, 64'h0);
        chk("rst_opc", a_opc, 64'h0);
        chk("rst_flags", {a_valid, a_busy, a_ovr, a_to}, 64'h0);
        rst = 1'b0;
        repeat (3) tick();
        chk("held_strobe_no_byte", a_busy, 64'h0);
        strb = 1'b0;
        tick();

        // Basic frame, i_ready=1
        send(8'h34); send(8'h12); send(8'h78); send(8'h56);
        chk("busy_mid_frame", a_busy, 64'h1);
        strobe(8'h25);
        chk("f1_valid", a_valid, 64'h1);
        chk("f1_op1", a_op1, 64'h1234);
        chk("f1_op2", a_op2, 64'h5678);
        chk("f1_opc", a_opc, 64'h25);
        chk("f1_busy", a_busy, 64'h0);
        tick();
        chk("f1_valid_drop", a_valid, 64'h0);

        // Long strobes, command left pending
        rdy = 1'b0;
        send_long(8'hCD); send_long(8'hAB); send_long(8'h01); send_long(8'hEF);
        send_long(8'h0A);
        chk("long_valid", a_valid, 64'h1);
        chk("long_op1", a_op1, 64'hABCD);
        chk("long_op2", a_op2, 64'hEF01);
        chk("long_opc", a_opc, 64'h0A);

        // Overrun while pending
        strobe(8'hAA);
        chk("ovr_pulse", a_ovr, 64'h1);
        chk("ovr_valid_held", a_valid, 64'h1);
        chk("ovr_op1_held", a_op1, 64'hABCD);
        chk("ovr_opc_held", a_opc, 64'h0A);
        tick();
        chk("ovr_pulse_end", a_ovr, 64'h0);
        rdy = 1'b1;
        tick();
        chk("ovr_accept_drop", a_valid, 64'h0);
        chk("ovr_busy_after", a_busy, 64'h0);

        // Timeout: last byte event in cycle t, now at t+1
        send(8'h01); send(8'h02); strobe(8'h03);
        chk("to_busy", a_busy, 64'h1);
        repeat (999) tick();
        chk("to_not_yet", a_to, 64'h0);
        chk("to_busy_still", a_busy, 64'h1);
        tick();
        chk("to_pulse", a_to, 64'h1);
        chk("to_busy_clear", a_busy, 64'h0);
        tick();
        chk("to_pulse_end", a_to, 64'h0);
        send(8'h11); send(8'h00); send(8'h22); send(8'h00);
        strobe(8'h3F);
        chk("to_f_valid", a_valid, 64'h1);
        chk("to_f_op1", a_op1, 64'h0011);
        chk("to_f_op2", a_op2, 64'h0022);
        chk("to_f_opc", a_opc, 64'h3F);
        tick();

        // Byte coinciding with acceptance
        rdy = 1'b0;
        send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05);
        chk("b2b_pending", a_valid, 64'h1);
        chk("b2b_first_op1", a_op1, 64'h0201);
        rdy = 1'b1;
        strobe(8'hC4);
        chk("b2b_valid_drop", a_valid, 64'h0);
        chk("b2b_no_ovr", a_ovr, 64'h0);
        chk("b2b_busy", a_busy, 64'h1);
        tick();
        send(8'hB3); send(8'hD2); send(8'hE1);
        strobe(8'h7F);
        chk("b2b_valid", a_valid, 64'h1);
        chk("b2b_op1", a_op1, 64'hB3C4);
        chk("b2b_op2", a_op2, 64'hE1D2);
        chk("b2b_opc_masked", a_opc, 64'h3F);
        tick();

        // Reset mid-frame and while valid
        send(8'h55); send(8'h66); send(8'h77);
        do_reset();
        chk("midrst_busy", a_busy, 64'h0);
        chk("midrst_op1", a_op1, 64'h0);
        chk("midrst_opc", a_opc, 64'h0);
        rdy = 1'b0;
        send(8'h10); send(8'h20); send(8'h30); send(8'h40); send(8'h50);
        chk("vrst_pending", a_valid, 64'h1);
        do_reset();
        chk("vrst_valid", a_valid, 64'h0);
        chk("vrst_op1", a_op1, 64'h0);
        chk("vrst_op2", a_op2, 64'h0);
        chk("vrst_opc", a_opc, 64'h0);
        rdy = 1'b1;
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        strobe(8'h01);
        chk("post_rst_op1", a_op1, 64'hBEEF);
        chk("post_rst_op2", a_op2, 64'hDEAD);
        chk("post_rst_opc", a_opc, 64'h01);
        chk("post_rst_valid", a_valid, 64'h1);
        tick();

        // OPERAND_BYTES=1
        do_reset();
        send(8'h99);
        chk("ob1_busy", b_busy, 64'h1);
        do_reset();
        chk("ob1_rst_busy", b_busy, 64'h0);
        send(8'h5A); send(8'hA5);
        strobe(8'h81);
        chk("ob1_valid", b_valid, 64'h1);
        chk("ob1_op1", b_op1, 64'h5A);
        chk("ob1_op2", b_op2, 64'hA5);
        chk("ob1_opc", b_opc, 64'h01);
        tick();
        rdy = 1'b0;
        send(8'h11); send(8'h22); send(8'h33);
        chk("ob1_pending", b_valid, 64'h1);
        rdy = 1'b1;
        strobe(8'h44);
        chk("ob1_b2b_drop", b_valid, 64'h0);
        chk("ob1_b2b_no_ovr", b_ovr, 64'h0);
        tick();
        send(8'h55);
        strobe(8'h66);
        chk("ob1_b2b_op1", b_op1, 64'h44);
        chk("ob1_b2b_op2", b_op2, 64'h55);
        chk("ob1_b2b_opc", b_opc, 64'h26);
        tick();

        // OPERAND_BYTES=4
        do_reset();
        send(8'hF1); send(8'hF2); send(8'hF3);
        chk("ob4_busy", c_busy, 64'h1);
        do_reset();
        chk("ob4_rst_busy", c_busy, 64'h0);
        for (int i = 1; i <= 8; i++) send(8'(i));
        chk("ob4_not_valid_yet", c_valid, 64'h0);
        strobe(8'hC9);
        chk("ob4_valid", c_valid, 64'h1);
        chk("ob4_op1", c_op1, 64'h04030201);
        chk("ob4_op2", c_op2, 64'h08070605);
        chk("ob4_opc", c_opc, 64'h09);
        tick();
        chk("ob4_valid_drop", c_valid, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
